// File: rtl/serial_tx_pkg.sv
// serial_tx_pkg: shared state encoding, field widths and 7-segment patterns for the serial transmitter
package serial_tx_pkg;
  localparam int PORT_W = 2;
  localparam int CNT_W  = 4;
  typedef enum logic [2:0] {IDLE, PORT, COUNT, TRANSMIT, DONE} state_t;
  localparam logic [6:0] SEG_LUT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
endpackage

// File: rtl/one_pulser.sv
// one_pulser: synchronizes a raw button and emits a one-cycle step per rising edge
module one_pulser (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic step
);
  logic [1:0] sync;
  logic       prev;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[0], din};
      prev <= sync[1];
    end
  assign step = sync[1] & ~prev;
endmodule

// File: rtl/seven_seg_decoder.sv
// seven_seg_decoder: 4-bit value to active-low {g,f,e,d,c,b,a} hex digit
module seven_seg_decoder
  import serial_tx_pkg::*;
(
  input  logic [3:0] val,
  output logic [6:0] seg
);
  assign seg = SEG_LUT[val];
endmodule

// File: rtl/top.sv
// top: button-clocked serial frame receiver routing payload bits to one of four channels
module top
  import serial_tx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clkPB,
  input  logic       Ser_In,
  output logic       SerOutValid,
  output logic       done,
  output logic       p0,
  output logic       p1,
  output logic       p2,
  output logic       p3,
  output logic [6:0] SSD1,
  output logic [6:0] SSD2
);
  state_t            state, next_state;
  logic              step;
  logic [PORT_W-1:0] port_reg;
  logic [CNT_W-1:0]  cnt_reg, cnt_shift;
  logic [1:0]        bit_cnt;
  logic [3:0]        p;
  assign cnt_shift = {cnt_reg[CNT_W-2:0], Ser_In};
  one_pulser u_pulser (.clk(clk), .rst(rst), .din(clkPB), .step(step));
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= next_state;
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     next_state = (step && !Ser_In) ? PORT : IDLE;
      PORT:     next_state = (step && bit_cnt == 2'd1) ? COUNT : PORT;
      COUNT:    next_state = (step && bit_cnt == 2'd3) ? ((cnt_shift != '0) ? TRANSMIT : DONE) : COUNT;
      TRANSMIT: next_state = (step && cnt_reg == CNT_W'(1)) ? DONE : TRANSMIT;
      DONE:     next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end
  // bit counter restarts on every state change so each field counts from zero
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      port_reg <= '0;
      cnt_reg  <= '0;
      bit_cnt  <= '0;
    end else begin
      bit_cnt  <= (state != next_state) ? 2'd0 : step ? bit_cnt + 2'd1 : bit_cnt;
      port_reg <= (state == PORT && step) ? {port_reg[PORT_W-2:0], Ser_In} : port_reg;
      cnt_reg  <= (state == COUNT && step) ? cnt_shift :
                  (state == TRANSMIT && step) ? cnt_reg - CNT_W'(1) : cnt_reg;
    end
  always_comb begin
    SerOutValid = (state == TRANSMIT);
    done        = (state == DONE);
    p           = (SerOutValid && Ser_In) ? (4'b0001 << port_reg) : 4'b0000;
  end
  assign {p3, p2, p1, p0} = p;
  seven_seg_decoder u_ssd1 (.val({2'b00, port_reg}), .seg(SSD1));
  seven_seg_decoder u_ssd2 (.val(cnt_reg), .seg(SSD2));
endmodule

// File: tb/tb_top.sv
// tb_top: randomized frame stimulus checked against a frame-level reference model
module tb_top;
  logic       clk = 1'b0, rst = 1'b0, clkPB = 1'b0, Ser_In = 1'b1;
  logic       SerOutValid, done, p0, p1, p2, p3;
  logic [6:0] SSD1, SSD2;
  int         n_tests = 0, n_fail = 0;
  logic [6:0] seg_ref [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  bit in_frame = 0;
  int k = 0, m_port = 0, m_cnt = 0;
  top dut (.clk(clk), .rst(rst), .clkPB(clkPB), .Ser_In(Ser_In), .SerOutValid(SerOutValid),
           .done(done), .p0(p0), .p1(p1), .p2(p2), .p3(p3), .SSD1(SSD1), .SSD2(SSD2));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic check_outs(input string tag, input logic b);
    bit       tx = in_frame && k >= 6;
    logic [3:0] pe = (tx && b) ? 4'(1 << m_port) : 4'd0;
    check({tag, "_valid"}, SerOutValid, tx);
    check({tag, "_p"}, {p3, p2, p1, p0}, pe);
    check({tag, "_ssd1"}, SSD1, seg_ref[m_port]);
    check({tag, "_ssd2"}, SSD2, seg_ref[m_cnt]);
    check({tag, "_done"}, done, 0);
  endtask
  task automatic model_reset();
    in_frame = 0; k = 0; m_port = 0; m_cnt = 0;
  endtask
  task automatic press(input logic b, input int hold);
    int dn = 0;
    int fin = 0;
    Ser_In = b;
    @(negedge clk);
    check_outs("pre", b);
    if (!in_frame) begin
      if (!b) begin in_frame = 1; k = 0; end
    end else begin
      k++;
      if (k <= 2) m_port = ((m_port << 1) | int'(b)) & 3;
      else if (k <= 6) begin
        m_cnt = ((m_cnt << 1) | int'(b)) & 15;
        if (k == 6 && m_cnt == 0) begin fin = 1; in_frame = 0; end
      end else begin
        m_cnt--;
        if (m_cnt == 0) begin fin = 1; in_frame = 0; end
      end
    end
    clkPB = 1'b1;
    repeat (hold) begin @(negedge clk); dn += int'(done); end
    clkPB = 1'b0;
    repeat (4) begin @(negedge clk); dn += int'(done); end
    check("done_cycles", dn, fin);
    check_outs("post", b);
  endtask
  task automatic send_frame(input int port, input int cnt);
    press(1'b0, 6);
    for (int i = 1; i >= 0; i--) press(1'(port >> i), 6);
    for (int i = 3; i >= 0; i--) press(1'(cnt >> i), 6);
    for (int i = 0; i < cnt; i++) press(1'($urandom_range(1)), 6);
  endtask
  initial begin
    #1;
    check("rst_valid", SerOutValid, 0);
    check("rst_done", done, 0);
    check("rst_p", {p3, p2, p1, p0}, 0);
    check("rst_ssd1", SSD1, 7'b1000000);
    check("rst_ssd2", SSD2, 7'b1000000);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    // frame to channel 2 with payload 1,0,1
    press(1'b0, 6);
    press(1'b1, 6); press(1'b0, 6);
    press(1'b0, 6); press(1'b0, 6); press(1'b1, 6); press(1'b1, 6);
    check("ch2_ssd1", SSD1, 7'b0100100);
    press(1'b1, 6); press(1'b0, 6); press(1'b1, 6);
    // zero-length frame to channel 3
    press(1'b0, 6);
    press(1'b1, 6); press(1'b1, 6);
    press(1'b0, 6); press(1'b0, 6); press(1'b0, 6); press(1'b0, 6);
    check("zero_ssd1", SSD1, 7'b0110000);
    repeat (5) press(1'b1, 6);
    // a long hold must yield a single step: start bit then held port bit
    press(1'b0, 50);
    press(1'b0, 50);
    press(1'b1, 6);
    for (int i = 0; i < 4; i++) press(1'(i == 3), 6);
    press(1'b1, 6);
    // mid-frame reset during payload
    send_frame(1, 0);
    press(1'b0, 6); press(1'b0, 6); press(1'b1, 6);
    press(1'b0, 6); press(1'b1, 6); press(1'b0, 6); press(1'b1, 6);
    press(1'b1, 6); press(1'b0, 6);
    Ser_In = 1'b1;
    @(negedge clk);
    check("mid_valid_before", SerOutValid, 1);
    #2 rst = 1'b0;
    #1;
    check("mid_valid", SerOutValid, 0);
    check("mid_p", {p3, p2, p1, p0}, 0);
    check("mid_ssd1", SSD1, 7'b1000000);
    check("mid_ssd2", SSD2, 7'b1000000);
    begin
      int dn = 0;
      repeat (5) begin @(negedge clk); dn += int'(done); end
      check("mid_no_done", dn, 0);
    end
    rst = 1'b1;
    model_reset();
    send_frame(3, 2);
    for (int f = 0; f < 20; f++) begin
      repeat ($urandom_range(2)) press(1'b1, 6);
      send_frame(int'($urandom_range(3)), int'($urandom_range(7)));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
